// File: rtl/round_controller.sv
// round_controller: two-player door-guessing game sequencer (rounds, judging, pause, lives, winner)
module round_controller #(
    parameter int TICKS_PER_SEC = 25_000_000,
    parameter int ROUND_SECS    = 10,
    parameter int PAUSE_TICKS   = 25_000_000,
    parameter int LIVES_INIT    = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [1:0] correct_door_1,
    input  logic [1:0] correct_door_2,
    input  logic [1:0] player_1_pos,
    input  logic [1:0] player_2_pos,
    output logic [3:0] seconds,
    output logic       time_up,
    output logic       resume,
    output logic [1:0] p1_lives,
    output logic [1:0] p2_lives,
    output logic       game_over,
    output logic [1:0] winner,
    output logic [2:0] state
);

    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int QW = (PAUSE_TICKS > 1) ? $clog2(PAUSE_TICKS) : 1;
    localparam logic [PW-1:0] PRE_LAST   = PW'(TICKS_PER_SEC - 1);
    localparam logic [QW-1:0] PAUSE_LAST = QW'(PAUSE_TICKS - 1);
    localparam logic [3:0]    SEC_END    = 4'(ROUND_SECS);
    localparam logic [1:0]    LIVES      = 2'(LIVES_INIT);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PLAY  = 3'd1,
        JUDGE = 3'd2,
        PAUSE = 3'd3,
        OVER  = 3'd4
    } state_t;

    state_t        cur, nxt;
    logic [PW-1:0] pre, pre_n;
    logic [QW-1:0] pcnt, pcnt_n;
    logic [3:0]    sec, sec_n;
    logic [1:0]    l1, l1_n, l2, l2_n;
    logic [1:0]    j1, j2;

    // Lives as they would stand after judging the current door choices (saturating at 0)
    always_comb begin
        j1 = (player_1_pos != correct_door_1 && l1 != 2'd0) ? l1 - 2'd1 : l1;
        j2 = (player_2_pos != correct_door_2 && l2 != 2'd0) ? l2 - 2'd1 : l2;
    end

    // Next-state and datapath update for every game phase
    always_comb begin
        nxt    = cur;
        pre_n  = pre;
        pcnt_n = pcnt;
        sec_n  = sec;
        l1_n   = l1;
        l2_n   = l2;
        case (cur)
            IDLE: begin
                l1_n  = LIVES;
                l2_n  = LIVES;
                sec_n = 4'd0;
                pre_n = '0;
                if (start) nxt = PLAY;
            end
            PLAY: begin
                if (pre == PRE_LAST) begin
                    pre_n = '0;
                    sec_n = sec + 4'd1;
                    if (sec + 4'd1 == SEC_END) nxt = JUDGE;
                end else begin
                    pre_n = pre + PW'(1);
                end
            end
            JUDGE: begin
                l1_n   = j1;
                l2_n   = j2;
                pcnt_n = '0;
                nxt    = (j1 == 2'd0 || j2 == 2'd0) ? OVER : PAUSE;
            end
            PAUSE: begin
                if (pcnt == PAUSE_LAST) begin
                    sec_n = 4'd0;
                    pre_n = '0;
                    nxt   = PLAY;
                end else begin
                    pcnt_n = pcnt + QW'(1);
                end
            end
            OVER: begin
                if (start) begin
                    l1_n  = LIVES;
                    l2_n  = LIVES;
                    sec_n = 4'd0;
                    pre_n = '0;
                    nxt   = PLAY;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any game in progress
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur  <= IDLE;
            pre  <= '0;
            pcnt <= '0;
            sec  <= 4'd0;
            l1   <= LIVES;
            l2   <= LIVES;
        end else begin
            cur  <= nxt;
            pre  <= pre_n;
            pcnt <= pcnt_n;
            sec  <= sec_n;
            l1   <= l1_n;
            l2   <= l2_n;
        end
    end

    assign state     = cur;
    assign seconds   = sec;
    assign p1_lives  = l1;
    assign p2_lives  = l2;
    assign time_up   = (cur == JUDGE) || (cur == PAUSE);
    assign resume    = (cur == PAUSE) && (pcnt == PAUSE_LAST);
    assign game_over = (cur == OVER);
    assign winner    = (cur == OVER) ? {l1 == 2'd0, l2 == 2'd0} : 2'b00;

endmodule

// File: tb/tb_round_controller.sv
// tb_round_controller: directed scenarios for round_controller with small timing parameters
module tb_round_controller;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic [1:0] correct_door_1 = 2'd2;
    logic [1:0] correct_door_2 = 2'd1;
    logic [1:0] player_1_pos = 2'd2;
    logic [1:0] player_2_pos = 2'd1;
    logic [3:0] seconds;
    logic       time_up;
    logic       resume;
    logic [1:0] p1_lives;
    logic [1:0] p2_lives;
    logic       game_over;
    logic [1:0] winner;
    logic [2:0] state;

    int n_checks = 0;
    int n_fail = 0;

    localparam logic [2:0] S_IDLE = 3'd0, S_PLAY = 3'd1, S_JUDGE = 3'd2, S_PAUSE = 3'd3, S_OVER = 3'd4;

    round_controller #(
        .TICKS_PER_SEC(4),
        .ROUND_SECS(3),
        .PAUSE_TICKS(5),
        .LIVES_INIT(2)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .start(start),
        .correct_door_1(correct_door_1),
        .correct_door_2(correct_door_2),
        .player_1_pos(player_1_pos),
        .player_2_pos(player_2_pos),
        .seconds(seconds),
        .time_up(time_up),
        .resume(resume),
        .p1_lives(p1_lives),
        .p2_lives(p2_lives),
        .game_over(game_over),
        .winner(winner),
        .state(state)
    );

    always #5 clk = ~clk;

    // {state, seconds, time_up, resume, game_over, winner, p1_lives, p2_lives}
    function automatic logic [15:0] snap();
        return {state, seconds, time_up, resume, game_over, winner, p1_lives, p2_lives};
    endfunction

    // {state, time_up, resume, game_over, winner, p1_lives, p2_lives}
    function automatic logic [11:0] flags();
        return {state, time_up, resume, game_over, winner, p1_lives, p2_lives};
    endfunction

    task automatic start_game(input string tag);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_checks++;
        if (snap() !== {S_PLAY, 4'd0, 1'b0, 1'b0, 1'b0, 2'b00, 2'd2, 2'd2}) begin
            n_fail++;
            $display("FAIL %s start_game: got %b want %b", tag, snap(),
                     {S_PLAY, 4'd0, 1'b0, 1'b0, 1'b0, 2'b00, 2'd2, 2'd2});
        end
    endtask

    // Runs 12 PLAY cycles from the start of a round, ends inside JUDGE with final positions applied
    task automatic play_round(input bit noisy, input logic [1:0] f1, input logic [1:0] f2);
        for (int c = 1; c <= 12; c++) begin
            if (noisy) begin
                player_1_pos = c[0] ? 2'd0 : 2'd3;
                player_2_pos = c[0] ? 2'd3 : 2'd0;
                start = c[0];
            end
            @(posedge clk); #1;
            n_checks++;
            if (c < 12) begin
                if ({state, seconds, time_up} !== {S_PLAY, 4'(c / 4), 1'b0}) begin
                    n_fail++;
                    $display("FAIL play cycle %0d: state/sec/tu got %b want %b", c,
                             {state, seconds, time_up}, {S_PLAY, 4'(c / 4), 1'b0});
                end
            end else begin
                if ({state, seconds, time_up} !== {S_JUDGE, 4'd3, 1'b1}) begin
                    n_fail++;
                    $display("FAIL judge entry: state/sec/tu got %b want %b",
                             {state, seconds, time_up}, {S_JUDGE, 4'd3, 1'b1});
                end
            end
        end
        start = 1'b0;
        player_1_pos = f1;
        player_2_pos = f2;
    endtask

    // Follows the edge out of JUDGE through 5 PAUSE cycles and into the next PLAY
    task automatic run_pause(input bit noisy);
        for (int k = 1; k <= 5; k++) begin
            start = noisy && k[0];
            @(posedge clk); #1;
            n_checks++;
            if ({state, seconds, time_up, resume} !== {S_PAUSE, 4'd3, 1'b1, k == 5}) begin
                n_fail++;
                $display("FAIL pause cycle %0d: state/sec/tu/resume got %b want %b", k,
                         {state, seconds, time_up, resume}, {S_PAUSE, 4'd3, 1'b1, k == 5});
            end
        end
        start = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if ({state, seconds, time_up, resume} !== {S_PLAY, 4'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL after pause: state/sec/tu/resume got %b want %b",
                     {state, seconds, time_up, resume}, {S_PLAY, 4'd0, 1'b0, 1'b0});
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (snap() !== {S_IDLE, 4'd0, 1'b0, 1'b0, 1'b0, 2'b00, 2'd2, 2'd2}) begin
            n_fail++;
            $display("FAIL reset values: got %b want %b", snap(),
                     {S_IDLE, 4'd0, 1'b0, 1'b0, 1'b0, 2'b00, 2'd2, 2'd2});
        end
        start = 1'b0;
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (state !== S_IDLE) begin
                n_fail++;
                $display("FAIL idle hold %0d: state got %0d want %0d", i, state, S_IDLE);
            end
        end
    endtask

    task automatic test_both_correct;
        start_game("both_correct");
        play_round(1'b0, 2'd2, 2'd1);
        run_pause(1'b0);
        n_checks++;
        if ({p1_lives, p2_lives} !== {2'd2, 2'd2}) begin
            n_fail++;
            $display("FAIL both_correct lives: got %0d/%0d want 2/2", p1_lives, p2_lives);
        end
    endtask

    task automatic test_p1_eliminated;
        play_round(1'b0, 2'd0, 2'd1);
        run_pause(1'b0);
        n_checks++;
        if ({p1_lives, p2_lives} !== {2'd1, 2'd2}) begin
            n_fail++;
            $display("FAIL p1 first miss lives: got %0d/%0d want 1/2", p1_lives, p2_lives);
        end
        play_round(1'b0, 2'd3, 2'd1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (flags() !== {S_OVER, 1'b0, 1'b0, 1'b1, 2'b10, 2'd0, 2'd2}) begin
                n_fail++;
                $display("FAIL p1 eliminated over %0d: got %b want %b", i, flags(),
                         {S_OVER, 1'b0, 1'b0, 1'b1, 2'b10, 2'd0, 2'd2});
            end
        end
    endtask

    task automatic test_both_eliminated;
        start_game("restart_from_over");
        play_round(1'b0, 2'd0, 2'd0);
        run_pause(1'b0);
        n_checks++;
        if ({p1_lives, p2_lives} !== {2'd1, 2'd1}) begin
            n_fail++;
            $display("FAIL both first miss lives: got %0d/%0d want 1/1", p1_lives, p2_lives);
        end
        play_round(1'b0, 2'd1, 2'd2);
        @(posedge clk); #1;
        n_checks++;
        if (flags() !== {S_OVER, 1'b0, 1'b0, 1'b1, 2'b11, 2'd0, 2'd0}) begin
            n_fail++;
            $display("FAIL both eliminated: got %b want %b", flags(),
                     {S_OVER, 1'b0, 1'b0, 1'b1, 2'b11, 2'd0, 2'd0});
        end
        start_game("reload_after_both");
    endtask

    task automatic test_ignore_inputs;
        play_round(1'b1, 2'd2, 2'd1);
        run_pause(1'b1);
        n_checks++;
        if ({p1_lives, p2_lives} !== {2'd2, 2'd2}) begin
            n_fail++;
            $display("FAIL noisy round lives: got %0d/%0d want 2/2", p1_lives, p2_lives);
        end
    endtask

    task automatic test_reset_in_pause;
        play_round(1'b0, 2'd1, 2'd1);
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({state, p1_lives, p2_lives} !== {S_PAUSE, 2'd1, 2'd2}) begin
            n_fail++;
            $display("FAIL pre-reset pause: got %b want %b", {state, p1_lives, p2_lives},
                     {S_PAUSE, 2'd1, 2'd2});
        end
        reset_n = 1'b0;
        #2;
        n_checks++;
        if (snap() !== {S_IDLE, 4'd0, 1'b0, 1'b0, 1'b0, 2'b00, 2'd2, 2'd2}) begin
            n_fail++;
            $display("FAIL async reset in pause: got %b want %b", snap(),
                     {S_IDLE, 4'd0, 1'b0, 1'b0, 1'b0, 2'b00, 2'd2, 2'd2});
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({state, resume, time_up} !== {S_IDLE, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL post-reset idle %0d: state/resume/tu got %b want %b", i,
                         {state, resume, time_up}, {S_IDLE, 1'b0, 1'b0});
            end
        end
        start_game("after_reset");
    endtask

    initial begin
        test_reset;
        test_both_correct;
        test_p1_eliminated;
        test_both_eliminated;
        test_ignore_inputs;
        test_reset_in_pause;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/round_controller.md
ROUND_CONTROLLER -- requirements
Module: round_controller

Interface
REQ-001 Parameter TICKS_PER_SEC, default 25_000_000, clk cycles per game second (25 MHz pixel clock).
REQ-002 Parameter ROUND_SECS, default 10, round length in seconds; legal range 1..15.
REQ-003 Parameter PAUSE_TICKS, default 25_000_000, clk cycles of post-round pause.
REQ-004 Parameter LIVES_INIT, default 3, lives loaded per player at game start; legal range 1..3.
REQ-005 clk  in  1  pixel clock; all state changes on rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  level, sampled each cycle; starts a game from IDLE or OVER.
REQ-008 correct_door_1, correct_door_2  in  2 each  correct door per lane, from switches.
REQ-009 player_1_pos, player_2_pos  in  2 each  door currently chosen by each player.
REQ-010 seconds  out  4  elapsed seconds in current round.
REQ-011 time_up  out  1  high while a round is being judged or paused.
REQ-012 resume  out  1  one-cycle pulse when pause ends and next round begins.
REQ-013 p1_lives, p2_lives  out  2 each  remaining lives.
REQ-014 game_over  out  1  high in OVER.
REQ-015 winner  out  2  00 none, 01 player 1, 10 player 2, 11 both eliminated.
REQ-016 state  out  3  current FSM state, for LEDR debug.

Function
REQ-017 FSM states: IDLE, PLAY, JUDGE, PAUSE, OVER; encoding IDLE=0..OVER=4 on state output.
REQ-018 IDLE: lives held at LIVES_INIT, seconds=0, prescaler=0; start=1 -> PLAY next cycle.
REQ-019 PLAY: prescaler counts 0..TICKS_PER_SEC-1; cycle where prescaler=TICKS_PER_SEC-1 wraps it to 0 and increments seconds.
REQ-020 PLAY: increment that makes seconds=ROUND_SECS transitions to JUDGE on the same edge; seconds holds ROUND_SECS through JUDGE and PAUSE.
REQ-021 JUDGE: exactly one cycle; player N loses a life iff player_N_pos != correct_door_N sampled in that cycle; decrement saturates at 0.
REQ-022 JUDGE exit: if either post-decrement life count is 0 -> OVER, else -> PAUSE with pause counter cleared.
REQ-023 PAUSE: lasts exactly PAUSE_TICKS cycles; on last cycle resume=1, seconds and prescaler cleared, -> PLAY.
REQ-024 time_up=1 in JUDGE and PAUSE only; 0 in IDLE, PLAY, OVER.
REQ-025 OVER: game_over=1; winner=01 if only p2_lives=0, 10 if only p1_lives=0, 11 if both 0; winner=00 in all other states.
REQ-026 OVER with start=1: lives reload LIVES_INIT, seconds/prescaler cleared, -> PLAY next cycle.
REQ-027 start ignored in PLAY, JUDGE, PAUSE.
REQ-028 Door and position inputs ignored outside JUDGE; changes during PLAY have no effect.
REQ-029 seconds never exceeds ROUND_SECS; no wrap of the 4-bit counter.

Reset
REQ-030 reset_n=0 forces immediately, regardless of state: state=IDLE, seconds=0, prescaler=0, pause counter=0, time_up=0, resume=0, game_over=0, winner=00, p1_lives=p2_lives=LIVES_INIT.
REQ-031 Reset asserted mid-round or mid-pause abandons the game; no resume pulse is produced.
REQ-032 First state change after reset_n release requires start=1 sampled on a rising edge.

Verification (TICKS_PER_SEC=4, ROUND_SECS=3, PAUSE_TICKS=5, LIVES_INIT=2)
REQ-033 Reset then start=1 for one cycle -> PLAY; seconds steps 1,2,3 every 4 cycles; JUDGE entered on cycle 12 of PLAY; time_up rises with JUDGE.
REQ-034 Both players correct at JUDGE -> lives stay 2/2; time_up high 6 cycles (1 JUDGE + 5 PAUSE); resume single pulse on 5th PAUSE cycle; seconds=0 next cycle.
REQ-035 Player 1 wrong two rounds, player 2 always correct -> p1_lives 2,1,0; OVER after second JUDGE; game_over=1, winner=10, no resume pulse.
REQ-036 Both wrong two rounds -> lives 0/0, winner=11; start=1 in OVER -> lives 2/2, PLAY, winner=00.
REQ-037 Positions toggled every cycle during PLAY but correct at JUDGE -> no life lost; start pulses in PLAY/PAUSE -> no effect on seconds or state.
REQ-038 reset_n pulsed low during PAUSE -> outputs at reset values asynchronously, before next clk edge; state IDLE until start.
